// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: thermometer stall mask, timed flush FSM, stall watchdog.
// Optional performance counters are enabled with the PIPE_CTRL_PERF_EN macro.
module pipe_ctrl #(
  parameter int unsigned STAGES     = 6,
  parameter int unsigned FLUSH_LEN  = 1,
  parameter int unsigned WDOG_LIMIT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stall_req,
  input  logic              flush_req,
  input  logic [31:0]       flush_pc,
  output logic [STAGES-1:0] stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic              timeout,
  output logic [31:0]       stall_cycles,
  output logic [15:0]       flush_count
);

  localparam int unsigned CW = $clog2(FLUSH_LEN + 1);
  localparam int unsigned WW = $clog2(WDOG_LIMIT + 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     new_pc_q, new_pc_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic            timeout_q, timeout_d;
  logic            accept;
  logic            stall_any;
  logic [STAGES-1:0] stall_mask;

  // A stage stalls if it or any later stage requests a stall.
  always_comb begin
    logic seen;
    seen       = 1'b0;
    stall_mask = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      seen = seen | stall_req[STAGES-1-k];
      stall_mask[STAGES-1-k] = seen;
    end
  end

  assign stall     = (rst || state_q == FLUSH || flush_req) ? '0 : stall_mask;
  assign stall_any = |stall;
  assign accept    = (state_q == IDLE) && flush_req;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    new_pc_d = new_pc_q;
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d  = FLUSH;
          cnt_d    = CW'(FLUSH_LEN);
          new_pc_d = flush_pc;
        end
      end
      FLUSH: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!stall_any)                   wd_d = '0;
    else if (wd_q == WW'(WDOG_LIMIT)) wd_d = wd_q;
    else                              wd_d = wd_q + WW'(1);

    // Accepting a flush clears the sticky flag ahead of any set.
    if (accept) timeout_d = 1'b0;
    else        timeout_d = timeout_q | (stall_any && wd_d == WW'(WDOG_LIMIT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      new_pc_q  <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      new_pc_q  <= new_pc_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign flush   = (state_q == FLUSH);
  assign new_pc  = new_pc_q;
  assign timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] sc_q, sc_d;
  logic [15:0] fc_q, fc_d;

  always_comb begin
    sc_d = sc_q + {31'b0, stall[0]};
    fc_d = fc_q + {15'b0, accept};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sc_q <= '0;
      fc_q <= '0;
    end else begin
      sc_q <= sc_d;
      fc_q <= fc_d;
    end
  end

  assign stall_cycles = sc_q;
  assign flush_count  = fc_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: two instances (FLUSH_LEN 3 and 1) against a
// cycle-level behavioural model, plus directed literal checks and random stimulus.
module tb_pipe_ctrl;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_req;
  logic        flush_req;
  logic [31:0] flush_pc;

  logic [5:0]  stall0, stall1;
  logic        flush0, flush1, to0, to1;
  logic [31:0] new_pc0, new_pc1, sc0, sc1;
  logic [15:0] fc0, fc1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.STAGES(6), .FLUSH_LEN(3), .WDOG_LIMIT(LIM)) u_dut0 (
    .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req), .flush_pc(flush_pc),
    .stall(stall0), .flush(flush0), .new_pc(new_pc0), .timeout(to0),
    .stall_cycles(sc0), .flush_count(fc0)
  );

  pipe_ctrl #(.STAGES(6), .FLUSH_LEN(1), .WDOG_LIMIT(LIM)) u_dut1 (
    .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req), .flush_pc(flush_pc),
    .stall(stall1), .flush(flush1), .new_pc(new_pc1), .timeout(to1),
    .stall_cycles(sc1), .flush_count(fc1)
  );

  // Model state per instance: remaining flush cycles, redirect target,
  // consecutive stalled cycles, sticky timeout, perf counters.
  int          flen [2] = '{3, 1};
  int          left [2];
  logic [31:0] mpc  [2];
  int          run  [2];
  bit          mto  [2];
  logic [31:0] msc  [2];
  logic [15:0] mfc  [2];

  function automatic logic [5:0] exp_stall(int i);
    logic [5:0] m;
    int h;
    m = '0;
    h = -1;
    if (rst || left[i] > 0 || flush_req) return '0;
    for (int b = 0; b < 6; b++) if (stall_req[b]) h = b;
    for (int b = 0; b <= h; b++) m[b] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic [31:0] esc [2];
    logic [15:0] efc [2];
    for (int i = 0; i < 2; i++) begin
`ifdef PIPE_CTRL_PERF_EN
      esc[i] = msc[i];
      efc[i] = mfc[i];
`else
      esc[i] = '0;
      efc[i] = '0;
`endif
    end
    chk("stall0",   {26'b0, stall0}, {26'b0, exp_stall(0)});
    chk("flush0",   {31'b0, flush0}, {31'b0, left[0] > 0});
    chk("new_pc0",  new_pc0, mpc[0]);
    chk("timeout0", {31'b0, to0}, {31'b0, mto[0]});
    chk("stall_cycles0", sc0, esc[0]);
    chk("flush_count0", {16'b0, fc0}, {16'b0, efc[0]});
    chk("stall1",   {26'b0, stall1}, {26'b0, exp_stall(1)});
    chk("flush1",   {31'b0, flush1}, {31'b0, left[1] > 0});
    chk("new_pc1",  new_pc1, mpc[1]);
    chk("timeout1", {31'b0, to1}, {31'b0, mto[1]});
    chk("stall_cycles1", sc1, esc[1]);
    chk("flush_count1", {16'b0, fc1}, {16'b0, efc[1]});
  endtask

  task automatic step();
    logic [5:0] st;
    bit acc;
    for (int i = 0; i < 2; i++) begin
      st = exp_stall(i);
      if (rst) begin
        left[i] = 0; mpc[i] = '0; run[i] = 0; mto[i] = 0; msc[i] = '0; mfc[i] = '0;
      end else begin
        acc = (left[i] == 0) && flush_req;
        if (left[i] > 0) left[i]--;
        else if (flush_req) begin
          left[i] = flen[i];
          mpc[i]  = flush_pc;
          mfc[i]  = mfc[i] + 16'd1;
        end
        if (st != 0) run[i] = (run[i] >= LIM) ? LIM : run[i] + 1;
        else         run[i] = 0;
        if (acc)               mto[i] = 0;
        else if (run[i] == LIM) mto[i] = 1;
        if (st[0]) msc[i] = msc[i] + 32'd1;
      end
    end
  endtask

  task automatic drive(input bit r, input logic [5:0] s, input bit f, input logic [31:0] p);
    rst = r; stall_req = s; flush_req = f; flush_pc = p;
    #2;
    compare();
  endtask

  task automatic tick();
    @(posedge clk);
    step();
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      left[i] = 0; mpc[i] = '0; run[i] = 0; mto[i] = 0; msc[i] = '0; mfc[i] = '0;
    end
    rst = 1'b1; stall_req = '0; flush_req = 1'b0; flush_pc = '0;
    @(posedge clk); #1;
    drive(1, 6'b001000, 0, 0);
    chk("rst_stall_forced", {26'b0, stall0}, 32'h0);
    tick();
    drive(0, 0, 0, 0);
    chk("reset_flush", {31'b0, flush0}, 32'h0);
    chk("reset_new_pc", new_pc0, 32'h0);
    tick();

    // Thermometer stall mask
    drive(0, 6'b001000, 0, 0); chk("mask_001000", {26'b0, stall0}, 32'h0f); tick();
    drive(0, 6'b000100, 0, 0); chk("mask_000100", {26'b0, stall0}, 32'h07); tick();
    drive(0, 6'b001100, 0, 0); chk("mask_001100", {26'b0, stall0}, 32'h0f); tick();
    drive(0, 0, 0, 0); tick();

    // Flush pulse with a concurrent stall request
    drive(0, 6'b001000, 1, 32'h0000_0180);
    chk("flush_beats_stall", {26'b0, stall0}, 32'h0);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(0, 6'b001000, 0, 32'hdead_beef);
      chk("flush_len3_high", {31'b0, flush0}, 32'h1);
      chk("flush_len3_pc", new_pc0, 32'h180);
      tick();
    end
    drive(0, 0, 0, 0);
    chk("flush_len3_done", {31'b0, flush0}, 32'h0);
    chk("new_pc_hold", new_pc0, 32'h180);
    tick();

    // Watchdog: held stall sets timeout, flush clears it
    for (int c = 0; c < 6; c++) begin drive(0, 6'b000100, 0, 0); tick(); end
    drive(0, 0, 0, 0); chk("timeout_set", {31'b0, to0}, 32'h1); tick();
    drive(0, 0, 0, 0); chk("timeout_sticky", {31'b0, to0}, 32'h1); tick();
    drive(0, 0, 1, 32'h200); tick();
    drive(0, 0, 0, 0); chk("timeout_cleared", {31'b0, to0}, 32'h0); tick();
    for (int c = 0; c < 3; c++) begin drive(0, 0, 0, 0); tick(); end
    for (int c = 0; c < 3; c++) begin drive(0, 6'b000100, 0, 0); tick(); end
    drive(0, 0, 0, 0); tick();
    for (int c = 0; c < 3; c++) begin drive(0, 6'b000100, 0, 0); tick(); end
    drive(0, 0, 0, 0); chk("timeout_broken_run", {31'b0, to0}, 32'h0); tick();

    // flush_req held 5 cycles: FLUSH_LEN=1 alternates accept/flush
    for (int c = 0; c < 5; c++) begin
      drive(0, 0, 1, 32'h1000 + 32'(c));
      chk("alt_flush1", {31'b0, flush1}, {31'b0, c[0]});
      tick();
    end
    drive(0, 0, 0, 0);
    chk("alt_last_pc", new_pc1, 32'h1004);
    tick();
    for (int c = 0; c < 4; c++) begin drive(0, 0, 0, 0); tick(); end

    // Reset during the second cycle of a 3-cycle flush
    drive(0, 0, 1, 32'h240); tick();
    drive(0, 0, 0, 0); tick();
    drive(1, 0, 0, 0); chk("mid_flush_high", {31'b0, flush0}, 32'h1); tick();
    drive(0, 0, 0, 0);
    chk("rst_abort_flush", {31'b0, flush0}, 32'h0);
    chk("rst_abort_pc", new_pc0, 32'h0);
    tick();

    // Perf counters: 10 stalled cycles and 2 flushes after reset
    for (int c = 0; c < 10; c++) begin drive(0, 6'b000001, 0, 0); tick(); end
    drive(0, 0, 1, 32'h4); tick();
    for (int c = 0; c < 3; c++) begin drive(0, 0, 0, 0); tick(); end
    drive(0, 0, 1, 32'h8); tick();
    for (int c = 0; c < 3; c++) begin drive(0, 0, 0, 0); tick(); end
    drive(0, 0, 0, 0);
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_stall_cycles", sc0, 32'd10);
    chk("perf_flush_count", {16'b0, fc0}, 32'd2);
`else
    chk("perf_stall_cycles_off", sc0, 32'd0);
    chk("perf_flush_count_off", {16'b0, fc0}, 32'd0);
`endif
    tick();

    // Random stimulus
    for (int c = 0; c < 3000; c++) begin
      logic [5:0] s;
      s = ($urandom_range(0, 3) == 0) ? 6'b0 : 6'($urandom & $urandom);
      drive($urandom_range(0, 63) == 0, s, $urandom_range(0, 7) == 0, $urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
